// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a big-endian byte stream into 32-bit words and
// writes them into instruction memory. The CPU is stalled while loading.
//
// Ports:
//   clk, rst1         clock and synchronous active-high reset
//   start             load request; base_addr and word_count are captured with it
//   abort             cancels the load in progress
//   byte_valid,
//   byte_data,
//   byte_ready        byte stream handshake
//   pc_addr           CPU fetch address, passed to im_addr when not busy
//   im_addr, im_din,
//   im_wea            instruction memory write port
//   cpu_stall, busy   high while receiving or writing
//   done, err         one-cycle pulses for completion and rejected start
//   words_written     words written in the current or last load
module imem_boot_loader #(
   parameter int IMSIZE = 8,
   parameter int IM_MAX = 256
) (
   input  logic              clk,
   input  logic              rst1,
   input  logic              start,
   input  logic [IMSIZE-1:0] base_addr,
   input  logic [IMSIZE:0]   word_count,
   input  logic              abort,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic [IMSIZE-1:0] pc_addr,
   output logic [IMSIZE-1:0] im_addr,
   output logic [31:0]       im_din,
   output logic              im_wea,
   output logic              cpu_stall,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [IMSIZE:0]   words_written
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // One bit wider than word_count so an out-of-range count compares cleanly.
   localparam logic [IMSIZE+1:0] MAX_W = (IMSIZE+2)'(IM_MAX);
   localparam logic [IMSIZE:0]   ONE_W = (IMSIZE+1)'(1);

   state_t            state, state_n;
   logic [IMSIZE-1:0] ptr, ptr_n;
   logic [IMSIZE:0]   left, left_n;
   logic [IMSIZE:0]   ww, ww_n;
   logic [31:0]       word, word_n;
   logic [31:0]       din_q, din_n;
   logic [1:0]        bcnt, bcnt_n;
   logic              err_q, err_n;
   logic              cnt_ok;

   assign cnt_ok = (word_count != '0) && ({1'b0, word_count} <= MAX_W);

   always_ff @(posedge clk) begin
      if (rst1) begin
         state <= IDLE;
         ptr   <= '0;
         left  <= '0;
         ww    <= '0;
         word  <= '0;
         din_q <= '0;
         bcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         left  <= left_n;
         ww    <= ww_n;
         word  <= word_n;
         din_q <= din_n;
         bcnt  <= bcnt_n;
         err_q <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      left_n  = left;
      ww_n    = ww;
      word_n  = word;
      din_n   = din_q;
      bcnt_n  = bcnt;
      err_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (cnt_ok) begin
                  ptr_n   = base_addr;
                  left_n  = word_count;
                  ww_n    = '0;
                  bcnt_n  = '0;
                  state_n = RECV;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         RECV: begin
            // abort wins over a simultaneous 4th byte
            if (abort) begin
               bcnt_n  = '0;
               word_n  = '0;
               state_n = IDLE;
            end else if (byte_valid) begin
               word_n = {word[23:0], byte_data};
               bcnt_n = bcnt + 2'd1;
               if (bcnt == 2'd3) begin
                  state_n = WRITE;
               end
            end
         end
         WRITE: begin
            din_n  = word;
            ptr_n  = ptr + 1'b1;
            left_n = left - ONE_W;
            ww_n   = ww + ONE_W;
            if (abort) begin
               state_n = IDLE;
            end else if (left == ONE_W) begin
               state_n = DONE;
            end else begin
               state_n = RECV;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
      endcase
   end

   assign busy          = (state == RECV) || (state == WRITE);
   assign cpu_stall     = busy;
   assign byte_ready    = (state == RECV);
   assign im_wea        = (state == WRITE);
   assign im_din        = im_wea ? word : din_q;
   assign im_addr       = busy ? ptr : pc_addr;
   assign done          = (state == DONE);
   assign err           = err_q;
   assign words_written = ww;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected writes are queued from the
// load requests and checked every cycle; literal checks pin key cycles.
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        rst1;
   logic        start;
   logic [7:0]  base_addr;
   logic [8:0]  word_count;
   logic        abort;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic [7:0]  pc_addr;
   logic [7:0]  im_addr;
   logic [31:0] im_din;
   logic        im_wea;
   logic        cpu_stall;
   logic        busy;
   logic        done;
   logic        err;
   logic [8:0]  words_written;

   int n_pass = 0;
   int n_tot  = 0;
   int done_cnt = 0;
   logic [39:0] exp_q[$];

   always #5 clk = ~clk;

   imem_boot_loader #(.IMSIZE(8), .IM_MAX(256)) dut (
      .clk(clk),
      .rst1(rst1),
      .start(start),
      .base_addr(base_addr),
      .word_count(word_count),
      .abort(abort),
      .byte_valid(byte_valid),
      .byte_data(byte_data),
      .byte_ready(byte_ready),
      .pc_addr(pc_addr),
      .im_addr(im_addr),
      .im_din(im_din),
      .im_wea(im_wea),
      .cpu_stall(cpu_stall),
      .busy(busy),
      .done(done),
      .err(err),
      .words_written(words_written)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic do_start(input logic [7:0] b, input logic [8:0] c);
      base_addr  = b;
      word_count = c;
      start      = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int k;
      repeat (gap) tick();
      byte_valid = 1'b1;
      byte_data  = b;
      k = 0;
      while (!byte_ready && k < 20) begin
         tick();
         k++;
      end
      if (!byte_ready) begin
         n_tot++;
         $display("FAIL byte_ready_timeout: got 0 expected 1");
      end
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int i = 3; i >= 0; i--)
         send_byte(w[i*8 +: 8], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
   endtask

   task automatic wait_done();
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("done_seen", 64'(seen), 64'd1);
   endtask

   // Every-cycle compare against the write queue and the static output rules.
   always @(negedge clk) begin
      logic [39:0] e;
      if (!rst1) begin
         if (done) done_cnt++;
         chk("stall_eq_busy", 64'(cpu_stall), 64'(busy));
         if (!busy) chk("fetch_pass", 64'(im_addr), 64'(pc_addr));
         if (im_wea) begin
            if (exp_q.size() == 0) begin
               n_tot++;
               $display("FAIL unexpected_write: addr %0h din %0h expected none",
                        im_addr, im_din);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 64'(im_addr), 64'(e[39:32]));
               chk("wr_din", 64'(im_din), 64'(e[31:0]));
            end
         end
      end
   end

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_stall"}, 64'(cpu_stall), 64'd0);
      chk({nm, "_ready"}, 64'(byte_ready), 64'd0);
      chk({nm, "_wea"}, 64'(im_wea), 64'd0);
      chk({nm, "_done"}, 64'(done), 64'd0);
      chk({nm, "_err"}, 64'(err), 64'd0);
      chk({nm, "_ww"}, 64'(words_written), 64'd0);
      chk({nm, "_din"}, 64'(im_din), 64'd0);
      chk({nm, "_addr"}, 64'(im_addr), 64'(pc_addr));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      rst1 = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
      abort = 1'b0; byte_valid = 1'b0; byte_data = '0; pc_addr = 8'h11;
      repeat (2) tick();
      @(negedge clk);
      chk_reset_vals("reset");
      tick();
      rst1 = 1'b0;
      tick();

      // single word at address 2
      push_exp(8'd2, 32'h8C0A0000);
      do_start(8'd2, 9'd1);
      send_word(32'h8C0A0000, 0);
      @(negedge clk);
      chk("w1_wea", 64'(im_wea), 64'd1);
      chk("w1_addr", 64'(im_addr), 64'd2);
      chk("w1_din", 64'(im_din), 64'h8C0A0000);
      @(negedge clk);
      chk("w1_done", 64'(done), 64'd1);
      chk("w1_ww", 64'(words_written), 64'd1);
      chk("w1_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("w1_done_off", 64'(done), 64'd0);
      chk("w1_din_hold", 64'(im_din), 64'h8C0A0000);
      tick();

      // address wrap 254, 255, 0
      push_exp(8'd254, 32'hA0A1A2A3);
      push_exp(8'd255, 32'hB0B1B2B3);
      push_exp(8'd0, 32'hC0C1C2C3);
      do_start(8'd254, 9'd3);
      @(negedge clk);
      chk("wrap_stall", 64'(cpu_stall), 64'd1);
      send_word(32'hA0A1A2A3, 0);
      send_word(32'hB0B1B2B3, 0);
      send_word(32'hC0C1C2C3, 0);
      wait_done();
      chk("wrap_ww", 64'(words_written), 64'd3);
      tick();

      // rejected counts
      do_start(8'd5, 9'd0);
      @(negedge clk);
      chk("cnt0_err", 64'(err), 64'd1);
      chk("cnt0_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("cnt0_err_off", 64'(err), 64'd0);
      tick();
      do_start(8'd5, 9'd257);
      @(negedge clk);
      chk("cnt257_err", 64'(err), 64'd1);
      chk("cnt257_busy", 64'(busy), 64'd0);
      chk("cnt257_ww_kept", 64'(words_written), 64'd3);
      tick();

      // abort in the middle of word 2
      pc_addr = 8'h55;
      d0 = done_cnt;
      push_exp(8'd10, 32'h01020304);
      do_start(8'd10, 9'd4);
      send_word(32'h01020304, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_addr", 64'(im_addr), 64'h55);
      chk("abort_ww", 64'(words_written), 64'd1);
      repeat (3) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt), 64'(d0));
      tick();

      // random byte gaps, plus a start ignored while busy
      push_exp(8'd100, 32'hCAFEF00D);
      push_exp(8'd101, 32'h12345678);
      do_start(8'd100, 9'd2);
      word_count = 9'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("busy_start_no_err", 64'(err), 64'd0);
      tick();
      send_word(32'hCAFEF00D, 3);
      send_word(32'h12345678, 3);
      wait_done();
      chk("gap_ww", 64'(words_written), 64'd2);
      tick();

      // reset during word 3
      push_exp(8'd50, 32'h50505050);
      push_exp(8'd51, 32'h51515151);
      do_start(8'd50, 9'd4);
      send_word(32'h50505050, 0);
      send_word(32'h51515151, 0);
      send_byte(8'h52, 0);
      send_byte(8'h53, 0);
      rst1 = 1'b1;
      tick();
      @(negedge clk);
      chk_reset_vals("midrst");
      tick();
      rst1 = 1'b0;
      tick();
      push_exp(8'd7, 32'hDEADBEEF);
      do_start(8'd7, 9'd1);
      send_word(32'hDEADBEEF, 0);
      wait_done();
      chk("post_rst_ww", 64'(words_written), 64'd1);
      repeat (3) tick();

      chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
